echo_requester: RTL and testbench

- Initiator for the echo request/indication protocol.
- Issues a programmed burst of echoReq calls with sequential payloads to an echo server.
- Accepts the returning echo indications and checks each against a scoreboard of sent values, in order.
- Used as a traffic generator and self-checker at the software-facing side of the echo path.

---
 rtl/echo_requester.sv | 244 ++++++++++++++++++++++++
 tb/tb_echo_requester.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_requester.sv
// Echo requester: issues a burst of sequential echoReq payloads and checks returning echoes in order.
// Latency: first request the cycle after start; an echo is compared and retired in the cycle it is accepted.
// Backpressure: issue stalls on echoReq__RDY=0 or a full scoreboard; echoes are accepted only while outstanding.
module echo_requester #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  // burst control
  input  logic                   start__ENA,
  input  logic [COUNT_WIDTH-1:0] start_count,
  input  logic [DATA_WIDTH-1:0]  start_seed,
  output logic                   start__RDY,
  // request channel towards the server
  output logic                   echoReq__ENA,
  output logic [DATA_WIDTH-1:0]  echoReq_v,
  input  logic                   echoReq__RDY,
  // indication channel from the server
  input  logic                   echo__ENA,
  input  logic [DATA_WIDTH-1:0]  echo_v,
  output logic                   echo__RDY,
  // status
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent_count,
  output logic [COUNT_WIDTH-1:0] recv_count,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [DATA_WIDTH-1:0]  first_err_exp,
  output logic [DATA_WIDTH-1:0]  first_err_got
);

  // Scoreboard geometry. Depth is a power of two so the pointers wrap for free.
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);

  // Burst sequencing states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]             state_q,    state_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;
  logic [DATA_WIDTH-1:0]  next_val_q, next_val_d;
  logic [COUNT_WIDTH-1:0] sent_q,     sent_d;
  logic [COUNT_WIDTH-1:0] recv_q,     recv_d;
  logic [COUNT_WIDTH-1:0] err_q,      err_d;
  logic [DATA_WIDTH-1:0]  fexp_q,     fexp_d;
  logic [DATA_WIDTH-1:0]  fgot_q,     fgot_d;

  // Scoreboard of payloads sent but not yet echoed, oldest at rd_ptr.
  logic [DATA_WIDTH-1:0]  sb_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
  logic [OCC_W-1:0]       occ_q,      occ_d;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic                  sb_empty;
  logic                  sb_full;
  logic                  in_burst;
  logic                  can_start;
  logic                  start_fire;
  logic                  issue;
  logic                  echo_rdy;
  logic                  pop;
  logic [DATA_WIDTH-1:0] sb_head;
  logic                  mismatch;

  assign sb_empty   = (occ_q == '0);
  assign sb_full    = (occ_q == OCC_FULL);
  assign in_burst   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_fire = start__ENA & can_start;

  // A full scoreboard blocks issue even if an echo retires this cycle, so
  // the request path never depends combinationally on echo__ENA.
  assign issue = (state_q == ST_RUN) & (sent_q < count_q) & ~sb_full & echoReq__RDY;

  // Echoes are only taken while something is outstanding inside a burst;
  // stray echoes after a reset are refused because the scoreboard is empty.
  assign echo_rdy = in_burst & ~sb_empty;
  assign pop      = echo__ENA & echo_rdy;
  assign sb_head  = sb_mem[rd_ptr_q];
  assign mismatch = pop & (echo_v != sb_head);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------

  // Scoreboard pointers and occupancy: push on issue, pop on accepted echo.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (issue) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (issue && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !issue) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Burst counters, payload generator, error capture and state sequencing.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    next_val_d = next_val_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    err_d      = err_q;
    fexp_d     = fexp_q;
    fgot_d     = fgot_q;

    // Request side: payloads are consecutive and wrap at the data width.
    if (issue) begin
      next_val_d = next_val_q + DATA_WIDTH'(1);
      sent_d     = sent_q + COUNT_WIDTH'(1);
    end

    // Indication side: retire the oldest entry and record any mismatch.
    if (pop) begin
      recv_d = recv_q + COUNT_WIDTH'(1);
    end
    if (mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + COUNT_WIDTH'(1);
      end
      // Only the first mismatch of the burst is kept for debug.
      if (err_q == '0) begin
        fexp_d = sb_head;
        fgot_d = echo_v;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // No issue or pop can happen here, so the start values win cleanly.
        if (start_fire) begin
          count_d    = start_count;
          next_val_d = start_seed;
          sent_d     = '0;
          recv_d     = '0;
          err_d      = '0;
          fexp_d     = '0;
          fgot_d     = '0;
          state_d    = (start_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Last issue this edge: drain, or finish outright if nothing remains.
        if (sent_d == count_q) begin
          state_d = (occ_d == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (occ_d == '0) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      next_val_q <= '0;
      sent_q     <= '0;
      recv_q     <= '0;
      err_q      <= '0;
      fexp_q     <= '0;
      fgot_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      next_val_q <= next_val_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      err_q      <= err_d;
      fexp_q     <= fexp_d;
      fgot_q     <= fgot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Scoreboard storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge CLK) begin
    if (issue) begin
      sb_mem[wr_ptr_q] <= next_val_q;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign start__RDY    = can_start;
  assign echoReq__ENA  = issue;
  assign echoReq_v     = issue ? next_val_q : '0;
  assign echo__RDY     = echo_rdy;
  assign busy          = in_burst;
  assign done          = (state_q == ST_DONE);
  assign sent_count    = sent_q;
  assign recv_count    = recv_q;
  assign err_count     = err_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

`ifndef SYNTHESIS
  // Structural invariants of the scoreboard and request handshake.
  a_occ_bound: assert property (@(posedge CLK) disable iff (!nRST)
    occ_q <= OCC_FULL);
  a_issue_rdy: assert property (@(posedge CLK) disable iff (!nRST)
    echoReq__ENA |-> echoReq__RDY);
  a_idle_empty: assert property (@(posedge CLK) disable iff (!nRST)
    (state_q == ST_IDLE || state_q == ST_DONE) |-> (occ_q == '0));
`endif

endmodule

// File: tb/tb_echo_requester.sv
// Testbench for echo_requester: an echo-server model plus a count-based reference of the burst.
// Inputs are driven at the falling edge; outputs are read at the falling edge or #1 after the rising edge.
// Every scenario is bounded by a cycle budget so the run always reaches its summary line.
module tb_echo_requester;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          start__ENA = 1'b0;
  logic [CW-1:0] start_count = '0;
  logic [DW-1:0] start_seed = '0;
  logic          start__RDY;
  logic          echoReq__ENA;
  logic [DW-1:0] echoReq_v;
  logic          echoReq__RDY = 1'b0;
  logic          echo__ENA = 1'b0;
  logic [DW-1:0] echo_v = '0;
  logic          echo__RDY;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;
  logic [CW-1:0] recv_count;
  logic [CW-1:0] err_count;
  logic [DW-1:0] first_err_exp;
  logic [DW-1:0] first_err_got;

  always #5 CLK = ~CLK;

  echo_requester #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .COUNT_WIDTH(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .start__ENA(start__ENA), .start_count(start_count), .start_seed(start_seed), .start__RDY(start__RDY),
    .echoReq__ENA(echoReq__ENA), .echoReq_v(echoReq_v), .echoReq__RDY(echoReq__RDY),
    .echo__ENA(echo__ENA), .echo_v(echo_v), .echo__RDY(echo__RDY),
    .busy(busy), .done(done), .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a burst is fully described by seed, count and how many were sent/received.
  logic [DW-1:0] m_seed = '0;
  int            m_count = 0;
  int            m_sent = 0;
  int            m_recv = 0;
  logic [CW-1:0] m_err = '0;
  logic [DW-1:0] m_fexp = '0;
  logic [DW-1:0] m_fgot = '0;
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  // Server model: payloads it has received and not yet echoed.
  logic [DW-1:0] srv_q[$];

  typedef logic [3+3*CW+2*DW-1:0] stat_t;

  function automatic stat_t model_stat();
    return {m_active, m_done, !m_active, CW'(m_sent), CW'(m_recv), m_err, m_fexp, m_fgot};
  endfunction

  function automatic stat_t dut_stat();
    return {busy, done, start__RDY, sent_count, recv_count, err_count, first_err_exp, first_err_got};
  endfunction

  task automatic model_clear();
    m_count = 0; m_sent = 0; m_recv = 0; m_err = '0; m_fexp = '0; m_fgot = '0;
    m_active = 1'b0; m_done = 1'b0;
  endtask

  task automatic do_start(input int cnt, input logic [DW-1:0] seed);
    @(negedge CLK);
    start__ENA = 1'b1; start_count = CW'(cnt); start_seed = seed;
    echo__ENA = 1'b0; echo_v = '0;
    @(posedge CLK);
    #1 start__ENA = 1'b0;
    model_clear();
    m_count = cnt; m_seed = seed;
    m_active = (cnt != 0); m_done = (cnt == 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; start__ENA = 1'b0; echo__ENA = 1'b0; echo_v = '0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    model_clear();
  endtask

  // One clock of stimulus: server readiness, optional echo (optionally corrupted).
  // Returns observed and expected request/echo-ready values; advances the reference.
  task automatic tick(input bit req_rdy, input bit want_echo, input bit corrupt, input logic [DW-1:0] bad,
                      output bit eo, output logic [DW-1:0] vo, output bit ee, output logic [DW-1:0] ve,
                      output bit ro, output bit re);
    bit            fire;
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    @(negedge CLK);
    start__ENA = 1'b0;
    ro = echo__RDY;
    re = m_active && (m_sent != m_recv);
    fire = want_echo && echo__RDY && (srv_q.size() > 0);
    got = '0;
    if (fire) got = corrupt ? bad : srv_q[0];
    echo__ENA = fire; echo_v = got;
    echoReq__RDY = req_rdy;
    #1;
    eo = echoReq__ENA; vo = echoReq_v;
    ee = m_active && (m_sent < m_count) && ((m_sent - m_recv) < MO) && req_rdy;
    ve = m_seed + DW'(m_sent);
    @(posedge CLK);
    if (fire) begin
      void'(srv_q.pop_front());
      exp = m_seed + DW'(m_recv);
      if (got != exp) begin
        if (m_err == '0) begin m_fexp = exp; m_fgot = got; end
        if (m_err != '1) m_err = m_err + 1'b1;
      end
      m_recv++;
    end
    if (eo) begin
      srv_q.push_back(vo);
      m_sent++;
    end
    if (m_active && m_sent == m_count && m_recv == m_count) begin
      m_active = 1'b0; m_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    echoReq__RDY = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, start__RDY, echoReq__ENA, echo__RDY, sent_count, recv_count, err_count, first_err_exp, first_err_got}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: busy/done/startRdy/ena/echoRdy=%b%b%b%b%b sent=%h recv=%h err=%h fexp=%h fgot=%h, want 00100 and zeros",
               busy, done, start__RDY, echoReq__ENA, echo__RDY, sent_count, recv_count, err_count, first_err_exp, first_err_got);
    end
  endtask

  task automatic test_basic();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    int issue_at[$];
    do_start(3, 32'h10);
    for (int c = 0; c < 40 && !m_done; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, eo, vo, ee, ve, ro, re);
      if (eo) issue_at.push_back(c);
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL basic_cycle%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
    end
    n_checks++;
    if (issue_at.size() != 3 || issue_at[0] != 0 || issue_at[1] != 1 || issue_at[2] != 2) begin
      n_fail++; $display("FAIL basic_issue_cycles: got %0d issues, want 3 on cycles 0,1,2", issue_at.size());
    end
    @(negedge CLK);
    n_checks++;
    if ({done, sent_count, recv_count, err_count} !== {1'b1, 16'd3, 16'd3, 16'd0} || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL basic_status: got %h want %h", dut_stat(), model_stat());
    end
  endtask

  task automatic test_window();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    do_start(8, 32'h200);
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b0, 1'b0, '0, eo, vo, ee, ve, ro, re);
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL window_hold%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if ({sent_count, echoReq__ENA, echo__RDY, busy} !== {16'd4, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL window_full: sent=%0d ena=%b echoRdy=%b busy=%b, want 4 0 1 1", sent_count, echoReq__ENA, echo__RDY, busy);
    end
    for (int c = 0; c < 60 && !m_done; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, eo, vo, ee, ve, ro, re);
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL window_release%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
    end
    @(negedge CLK);
    n_checks++;
    if ({done, recv_count} !== {1'b1, 16'd8} || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL window_status: got %h want %h", dut_stat(), model_stat());
    end
  endtask

  task automatic test_req_backpressure();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    int n_issued = 0;
    int n_stalled = 0;
    do_start(10, 32'h40);
    for (int c = 0; c < 80 && !m_done; c++) begin
      bit rdy = !(c >= 3 && c < 8);
      tick(rdy, 1'b1, 1'b0, '0, eo, vo, ee, ve, ro, re);
      if (eo) n_issued++;
      if (eo && !rdy) n_stalled++;
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL reqbp_cycle%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
    end
    @(negedge CLK);
    n_checks++;
    if (n_issued != 10 || n_stalled != 0 || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL reqbp_status: issued=%0d stalledIssues=%0d stat %h want 10 0 %h", n_issued, n_stalled, dut_stat(), model_stat());
    end
  endtask

  task automatic test_mismatch();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    do_start(3, 32'h10);
    for (int c = 0; c < 40 && !m_done; c++) begin
      bit c1 = (srv_q.size() > 0) && (srv_q[0] == 32'h11);
      bit c2 = (srv_q.size() > 0) && (srv_q[0] == 32'h12);
      tick(1'b1, 1'b1, c1 || c2, c1 ? 32'hDEAD : 32'hBEEF, eo, vo, ee, ve, ro, re);
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL mismatch_cycle%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
      if (c1) begin
        #1;
        n_checks++;
        if ({err_count, first_err_exp, first_err_got} !== {16'd1, 32'h11, 32'hDEAD}) begin
          n_fail++; $display("FAIL mismatch_first: err=%0d exp=%h got=%h want 1 11 dead", err_count, first_err_exp, first_err_got);
        end
      end
    end
    @(negedge CLK);
    n_checks++;
    if ({done, err_count, first_err_exp, first_err_got} !== {1'b1, 16'd2, 32'h11, 32'hDEAD} || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL mismatch_final: got %h want %h", dut_stat(), model_stat());
    end
  endtask

  task automatic test_wrap_zero();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    logic [DW-1:0] seen[$];
    logic [DW-1:0] wexp[3];
    wexp[0] = 32'hFFFFFFFE; wexp[1] = 32'hFFFFFFFF; wexp[2] = 32'h00000000;
    do_start(3, 32'hFFFFFFFE);
    for (int c = 0; c < 40 && !m_done; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, eo, vo, ee, ve, ro, re);
      if (eo) seen.push_back(vo);
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL wrap_cycle%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
    end
    n_checks++;
    if (seen.size() != 3 || seen[0] !== wexp[0] || seen[1] !== wexp[1] || seen[2] !== wexp[2]) begin
      n_fail++; $display("FAIL wrap_payloads: got %0d payloads, want fffffffe ffffffff 00000000", seen.size());
    end
    do_start(0, 32'h7);
    @(negedge CLK);
    n_checks++;
    if ({done, busy, sent_count} !== {1'b1, 1'b0, 16'd0} || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL zero_done: got %h want %h", dut_stat(), model_stat());
    end
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, eo, vo, ee, ve, ro, re);
      n_checks++;
      if ({eo, ro} !== {1'b0, 1'b0}) begin
        n_fail++; $display("FAIL zero_quiet%0d: ena=%b echoRdy=%b want 0 0", c, eo, ro);
      end
    end
  endtask

  task automatic test_reset_midburst();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    do_start(8, 32'h100);
    for (int c = 0; c < 20 && m_sent < 2; c++) begin
      tick(1'b1, 1'b0, 1'b0, '0, eo, vo, ee, ve, ro, re);
    end
    do_reset();
    @(negedge CLK);
    n_checks++;
    if ({busy, done, start__RDY, echo__RDY, sent_count} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'd0} || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL midreset_state: got %h echoRdy=%b want %h echoRdy=0", dut_stat(), echo__RDY, model_stat());
    end
    // A late echo from the aborted burst must not be taken.
    echo__ENA = 1'b1; echo_v = 32'h100;
    @(posedge CLK);
    #1 echo__ENA = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({recv_count, err_count, echo__RDY} !== {16'd0, 16'd0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_late_echo: recv=%0d err=%0d echoRdy=%b want 0 0 0", recv_count, err_count, echo__RDY);
    end
    srv_q.delete();
    do_start(4, 32'h55);
    for (int c = 0; c < 40 && !m_done; c++) begin
      tick(1'b1, 1'b1, 1'b0, '0, eo, vo, ee, ve, ro, re);
      n_checks++;
      if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
        n_fail++; $display("FAIL midreset_restart%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", c, eo, vo, ro, ee, ve, re);
      end
    end
    @(negedge CLK);
    n_checks++;
    if ({done, recv_count} !== {1'b1, 16'd4} || dut_stat() !== model_stat()) begin
      n_fail++; $display("FAIL midreset_restart_status: got %h want %h", dut_stat(), model_stat());
    end
  endtask

  task automatic test_random();
    bit eo, ee, ro, re; logic [DW-1:0] vo, ve;
    for (int b = 0; b < 6; b++) begin
      do_start(int'($urandom_range(1, 12)), $urandom);
      for (int c = 0; c < 400 && !m_done; c++) begin
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom,
             eo, vo, ee, ve, ro, re);
        n_checks++;
        if ({eo, eo ? vo : 32'h0, ro} !== {ee, ee ? ve : 32'h0, re}) begin
          n_fail++; $display("FAIL random%0d_cycle%0d: ena/v/echoRdy got %b/%h/%b want %b/%h/%b", b, c, eo, vo, ro, ee, ve, re);
        end
      end
      @(negedge CLK);
      n_checks++;
      if (done !== 1'b1 || dut_stat() !== model_stat()) begin
        n_fail++; $display("FAIL random%0d_status: got %h want %h", b, dut_stat(), model_stat());
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    model_clear();
    test_reset();
    test_basic();
    test_window();
    test_req_backpressure();
    test_mismatch();
    test_wrap_zero();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
